// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared definitions for the systolic array sequencer.
//   state_t       : sequencer FSM states
//   DEF_N         : default array dimension
//   DEF_MAX_ROWS  : default largest input row count per job
//   RD_LAT        : tile buffer read latency in cycles
package systolic_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_ROWS = 256;
  localparam int RD_LAT       = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN
  } state_t;

endpackage

// File: rtl/systolic_ctrl_dly.sv
// systolic_ctrl_dly
// Fixed-depth shift register carrying a {valid, idx} pair. It tracks an input
// row index from its buffer read strobe to the cycle its result leaves the array.
//   clk, rst      : clock, synchronous active-high reset (clears every stage)
//   i_valid/i_idx : entry into stage 0
//   o_valid/o_idx : last stage, DEPTH cycles after entry
//   o_any_valid   : any stage holds a valid entry (rows still in flight)
module systolic_ctrl_dly #(
  parameter int DEPTH = 5,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_idx,
  output logic         o_valid,
  output logic [W-1:0] o_idx,
  output logic         o_any_valid
);

  logic [DEPTH-1:0] w_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic         r_v;
      logic [W-1:0] r_i;
      logic         w_v_in;
      logic [W-1:0] w_i_in;

      if (gi == 0) begin : g_head
        assign w_v_in = i_valid;
        assign w_i_in = i_idx;
      end else begin : g_tail
        assign w_v_in = g_stage[gi-1].r_v;
        assign w_i_in = g_stage[gi-1].r_i;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
          r_i <= '0;
        end else begin
          r_v <= w_v_in;
          r_i <= w_i_in;
        end
      end

      assign w_valid[gi] = r_v;
    end
  endgenerate

  assign o_valid     = g_stage[DEPTH-1].r_v;
  assign o_idx       = g_stage[DEPTH-1].r_i;
  assign o_any_valid = |w_valid;

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl
// Sequencer for the NxN systolic array: loads one weight tile by vertical
// shifting, streams M input rows, then drains the array. Control only, no data.
//   clk, rst              : clock, synchronous active-high reset
//   start, cfg_rows       : job request (sampled in IDLE) and its row count M
//   busy, done            : job in progress, one-cycle end-of-job pulse
//   w_rd_en, w_rd_addr    : weight buffer read port (1-cycle latency)
//   i_rd_en, i_rd_addr    : input buffer read port (1-cycle latency)
//   wshift, pe_en,
//   mul_en, adder_en      : array control enables
//   out_valid, out_idx    : result row present on the array output, and its index
// N must not exceed MAX_ROWS (the shared counter is RW bits wide).
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int MAX_ROWS  = DEF_MAX_ROWS,
  parameter int ARRAY_LAT = N,
  localparam int RW       = $clog2(MAX_ROWS + 1),
  localparam int NW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] cfg_rows,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [NW-1:0] w_rd_addr,
  output logic          i_rd_en,
  output logic [RW-1:0] i_rd_addr,
  output logic          wshift,
  output logic          pe_en,
  output logic          mul_en,
  output logic          adder_en,
  output logic          out_valid,
  output logic [RW-1:0] out_idx
);

  state_t        r_state, w_state_next;
  logic [RW-1:0] r_rows, w_rows_next;
  logic [RW-1:0] r_cnt, w_cnt_next;
  logic          r_wshift;
  logic          r_done, w_done_next;
  logic          w_any_valid;

  // Next state, counters and buffer read strobes. The read strobes are
  // combinational from state so they line up with the counter value.
  always_comb begin
    w_state_next = r_state;
    w_rows_next  = r_rows;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    i_rd_en      = 1'b0;
    i_rd_addr    = '0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = LOAD;
          w_rows_next  = cfg_rows;
          w_cnt_next   = '0;
        end
      end
      LOAD: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_cnt[NW-1:0];
        if (r_cnt == RW'(N - 1)) begin
          w_cnt_next   = '0;
          w_state_next = (r_rows == '0) ? DRAIN : COMPUTE;
        end else begin
          w_cnt_next = r_cnt + RW'(1);
        end
      end
      COMPUTE: begin
        i_rd_en   = 1'b1;
        i_rd_addr = r_cnt;
        if (r_cnt == r_rows - RW'(1)) begin
          w_cnt_next   = '0;
          w_state_next = DRAIN;
        end else begin
          w_cnt_next = r_cnt + RW'(1);
        end
      end
      DRAIN: begin
        // Leave once the last row's result is on the output; an empty job
        // has nothing in flight and spends a single cycle here.
        if ((r_rows == '0) || (out_valid && (out_idx == r_rows - RW'(1)))) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rows   <= '0;
      r_cnt    <= '0;
      r_wshift <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rows   <= w_rows_next;
      r_cnt    <= w_cnt_next;
      r_wshift <= w_rd_en;
      r_done   <= w_done_next;
    end
  end

  // Stage 0 of this line is i_rd_en delayed by the buffer latency, i.e. the
  // first array cycle of a row; the last stage is the row's result cycle.
  // So "any stage valid" is exactly the multiply/accumulate window,
  // including the drain tail.
  systolic_ctrl_dly #(
    .DEPTH(RD_LAT + ARRAY_LAT),
    .W    (RW)
  ) u_out_dly (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_rd_en),
    .i_idx      (i_rd_addr),
    .o_valid    (out_valid),
    .o_idx      (out_idx),
    .o_any_valid(w_any_valid)
  );

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign wshift   = r_wshift;
  assign mul_en   = w_any_valid;
  assign adder_en = w_any_valid;
  assign pe_en    = r_wshift | w_any_valid;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl
// Drives systolic_ctrl (N=4, L=4) through directed and random jobs, and a
// second instance (N=8, L=9) through one maximum-size job. Expected outputs
// come from the cycle-window arithmetic of the job timeline.
module tb_systolic_ctrl;

  localparam int NA = 4;
  localparam int LA = 4;
  localparam int NB = 8;
  localparam int LB = 9;
  localparam int MR = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic       a_rst, a_start;
  logic [8:0] a_rows;
  logic       a_busy, a_done, a_w_en, a_i_en, a_wshift, a_pe, a_mul, a_add, a_ov;
  logic [1:0] a_w_addr;
  logic [8:0] a_i_addr, a_oidx;

  // Instance B
  logic       b_rst, b_start;
  logic [8:0] b_rows;
  logic       b_busy, b_done, b_w_en, b_i_en, b_wshift, b_pe, b_mul, b_add, b_ov;
  logic [2:0] b_w_addr;
  logic [8:0] b_i_addr, b_oidx;
  logic       b_fin;

  systolic_ctrl #(.N(NA), .MAX_ROWS(MR), .ARRAY_LAT(LA)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .cfg_rows(a_rows),
    .busy(a_busy), .done(a_done), .w_rd_en(a_w_en), .w_rd_addr(a_w_addr),
    .i_rd_en(a_i_en), .i_rd_addr(a_i_addr), .wshift(a_wshift), .pe_en(a_pe),
    .mul_en(a_mul), .adder_en(a_add), .out_valid(a_ov), .out_idx(a_oidx)
  );

  systolic_ctrl #(.N(NB), .MAX_ROWS(MR), .ARRAY_LAT(LB)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .cfg_rows(b_rows),
    .busy(b_busy), .done(b_done), .w_rd_en(b_w_en), .w_rd_addr(b_w_addr),
    .i_rd_en(b_i_en), .i_rd_addr(b_i_addr), .wshift(b_wshift), .pe_en(b_pe),
    .mul_en(b_mul), .adder_en(b_add), .out_valid(b_ov), .out_idx(b_oidx)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       w_en;
    logic [7:0] w_addr;
    logic       i_en;
    logic [8:0] i_addr;
    logic       wshift;
    logic       mul;
    logic       pe;
    logic       ov;
    logic [8:0] oidx;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  // Expected outputs at cycle t of a job (t=1 is the first cycle after the
  // accepting edge). t=0 or any cycle outside the job gives all zeros.
  function automatic exp_t model(input int n, input int l, input int m, input int t);
    exp_t e;
    int   last;
    e    = '0;
    last = (m == 0) ? n + 1 : n + m + 1 + l;
    e.busy   = (t >= 1) && (t <= last);
    e.done   = (t == last + 1);
    e.w_en   = (t >= 1) && (t <= n);
    if (e.w_en) e.w_addr = 8'(t - 1);
    e.i_en   = (t >= n + 1) && (t <= n + m);
    if (e.i_en) e.i_addr = 9'(t - n - 1);
    e.wshift = (t >= 2) && (t <= n + 1);
    e.mul    = (m > 0) && (t >= n + 2) && (t <= n + m + 1 + l);
    e.pe     = e.wshift | e.mul;
    e.ov     = (m > 0) && (t >= n + 2 + l) && (t <= n + 1 + l + m);
    if (e.ov) e.oidx = 9'(t - n - 2 - l);
    return e;
  endfunction

  task automatic check_out(input string ph, input int t, input exp_t e,
                           input logic busy, input logic done, input logic w_en,
                           input logic [7:0] w_addr, input logic i_en,
                           input logic [8:0] i_addr, input logic wsh,
                           input logic mul, input logic add, input logic pe,
                           input logic ov, input logic [8:0] oidx);
    check($sformatf("%s.busy@%0d", ph, t),   32'(busy),   32'(e.busy));
    check($sformatf("%s.done@%0d", ph, t),   32'(done),   32'(e.done));
    check($sformatf("%s.w_en@%0d", ph, t),   32'(w_en),   32'(e.w_en));
    check($sformatf("%s.w_addr@%0d", ph, t), 32'(w_addr), 32'(e.w_addr));
    check($sformatf("%s.i_en@%0d", ph, t),   32'(i_en),   32'(e.i_en));
    check($sformatf("%s.i_addr@%0d", ph, t), 32'(i_addr), 32'(e.i_addr));
    check($sformatf("%s.wshift@%0d", ph, t), 32'(wsh),    32'(e.wshift));
    check($sformatf("%s.mul@%0d", ph, t),    32'(mul),    32'(e.mul));
    check($sformatf("%s.adder@%0d", ph, t),  32'(add),    32'(e.mul));
    check($sformatf("%s.pe@%0d", ph, t),     32'(pe),     32'(e.pe));
    check($sformatf("%s.ov@%0d", ph, t),     32'(ov),     32'(e.ov));
    check($sformatf("%s.oidx@%0d", ph, t),   32'(oidx),   32'(e.oidx));
  endtask

  task automatic check_a(input string ph, input int m, input int t);
    check_out(ph, t, model(NA, LA, m, t), a_busy, a_done, a_w_en, 8'(a_w_addr),
              a_i_en, a_i_addr, a_wshift, a_mul, a_add, a_pe, a_ov, a_oidx);
  endtask

  task automatic idle_a(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_a("idle", 0, 0);
    end
  endtask

  // Caller has start=1 and cfg_rows=m set ahead of the next rising edge.
  // rst_at>0 asserts reset during cycle rst_at; next_m>=0 requests the next
  // job in the done cycle. Random start/cfg_rows are driven while busy.
  task automatic run_a(input int m, input int rst_at, input int next_m);
    int last, tmax;
    last = (m == 0) ? NA + 1 : NA + m + 1 + LA;
    tmax = (rst_at > 0) ? rst_at + 4 : last + 1;
    @(posedge clk);
    for (int t = 1; t <= tmax; t++) begin
      @(negedge clk);
      if (rst_at > 0 && t > rst_at) check_a("rst", 0, 0);
      else                          check_a("job", m, t);
      if (rst_at > 0 && t == rst_at) begin
        a_rst   = 1'b1;
        a_start = 1'($urandom);
      end else if (rst_at > 0 && t == rst_at + 1) begin
        a_rst   = 1'b0;
        a_start = 1'b0;
      end else if (rst_at > 0 && t > rst_at) begin
        a_start = 1'b0;
      end else if (t <= last) begin
        a_start = 1'($urandom);
        a_rows  = 9'($urandom);
      end else if (next_m >= 0) begin
        a_start = 1'b1;
        a_rows  = 9'(next_m);
      end else begin
        a_start = 1'b0;
      end
    end
    $display("job A M=%0d rst_at=%0d next=%0d checks=%0d errors=%0d", m, rst_at, next_m, checks, errors);
  endtask

  // Instance B: one maximum-size job.
  initial begin
    int last, nvalid, expect_idx;
    b_fin   = 1'b0;
    b_rst   = 1'b1;
    b_start = 1'b0;
    b_rows  = '0;
    nvalid  = 0;
    expect_idx = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    b_rst   = 1'b0;
    b_start = 1'b1;
    b_rows  = 9'(MR);
    last    = NB + MR + 1 + LB;
    @(posedge clk);
    for (int t = 1; t <= last + 2; t++) begin
      @(negedge clk);
      b_start = 1'b0;
      check_out("bjob", t, model(NB, LB, MR, t), b_busy, b_done, b_w_en, 8'(b_w_addr),
                b_i_en, b_i_addr, b_wshift, b_mul, b_add, b_pe, b_ov, b_oidx);
      if (b_ov) begin
        check($sformatf("b.contig@%0d", t), 32'(b_oidx), 32'(expect_idx));
        expect_idx++;
        nvalid++;
      end
      if (t == NB + MR + 2 + LB) check("b.done_at_275", 32'(b_done), 32'd1);
    end
    check("b.valid_count", 32'(nvalid), 32'(MR));
    $display("job B N=%0d L=%0d M=%0d valid_rows=%0d", NB, LB, MR, nvalid);
    b_fin = 1'b1;
  end

  // Instance A: directed then random jobs.
  initial begin
    int m, nm;
    a_rst   = 1'b1;
    a_start = 1'b0;
    a_rows  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_a("reset", 0, 0);
    a_start = 1'b1;  // held through reset: must not start a job
    a_rows  = 9'd5;
    @(negedge clk);
    check_a("reset_start", 0, 0);
    a_rst   = 1'b0;
    a_start = 1'b0;
    idle_a(2);

    // Basic M=3
    a_start = 1'b1; a_rows = 9'd3;
    run_a(3, 0, -1);
    idle_a(2);

    // Empty job
    a_start = 1'b1; a_rows = 9'd0;
    run_a(0, 0, -1);
    idle_a(1);

    // Back-to-back chain
    a_start = 1'b1; a_rows = 9'd1;
    run_a(1, 0, 1);
    run_a(1, 0, 0);
    run_a(0, 0, 2);
    run_a(2, 0, -1);
    idle_a(1);

    // Reset mid-COMPUTE, then the basic job again
    a_start = 1'b1; a_rows = 9'd3;
    run_a(3, 6, -1);
    idle_a(1);
    a_start = 1'b1; a_rows = 9'd3;
    run_a(3, 0, -1);
    idle_a(1);

    // Largest row count
    a_start = 1'b1; a_rows = 9'(MR);
    run_a(MR, 0, -1);
    idle_a(1);

    // Random jobs, chained or separated
    m = $urandom_range(0, 20);
    a_start = 1'b1; a_rows = 9'(m);
    for (int j = 0; j < 10; j++) begin
      nm = $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) begin
        run_a(m, 0, nm);
      end else begin
        run_a(m, 0, -1);
        idle_a($urandom_range(1, 3));
        a_start = 1'b1; a_rows = 9'(nm);
      end
      m = nm;
    end
    run_a(m, 0, -1);
    idle_a(2);

    for (int i = 0; i < 3000 && !b_fin; i++) @(posedge clk);
    check("b_finished", 32'(b_fin), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
